// File: rtl/wash_sequencer.sv
// Wash-cycle sequencer: SOAK -> WASH -> RINSE x(1+n_extra) -> SPIN -> DRY, with
// lid-open pause, abort-with-drain and remaining-time / rinse-index status.
module wash_sequencer #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SOAK_T    = 60,
  parameter int WASH_T    = 60,
  parameter int RINSE_T   = 60,
  parameter int SPIN_T    = 60,
  parameter int DRY_T     = 60,
  parameter int MAX_EXTRA = 3,
  parameter int CW        = 16,
  parameter int EW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin,
  input  logic [EW-1:0] extra_rinse,
  input  logic          lid_cl,
  input  logic          abort,
  output logic          soak_signal,
  output logic          wash_signal,
  output logic          rinse_signal,
  output logic          spin_signal,
  output logic          dry_signal,
  output logic          paused,
  output logic          completed,
  output logic          done,
  output logic          aborted,
  output logic [EW-1:0] rinse_num,
  output logic [CW-1:0] remaining
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [EW-1:0] EXTRA_MAX = EW'(MAX_EXTRA);

  typedef enum logic [2:0] {IDLE, SOAK, WASH, RINSE, SPIN, DRY} state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [CW-1:0] cnt_reg;
  logic [EW-1:0] rinse_num_reg;
  logic [EW-1:0] n_extra_reg;
  logic          drain_reg;
  logic          aborted_reg;
  logic          done_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      presc_reg     <= '0;
      cnt_reg       <= '0;
      rinse_num_reg <= '0;
      n_extra_reg   <= '0;
      drain_reg     <= 1'b0;
      aborted_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (coin) begin
          state_reg   <= SOAK;
          cnt_reg     <= CW'(SOAK_T);
          presc_reg   <= '0;
          aborted_reg <= 1'b0;
          drain_reg   <= 1'b0;
          n_extra_reg <= (extra_rinse > EXTRA_MAX) ? EXTRA_MAX : extra_rinse;
        end
      end else if (abort && state_reg != SPIN) begin
        // Abort wins over the lid and the tick; SPIN is already draining.
        presc_reg     <= '0;
        rinse_num_reg <= '0;
        if (state_reg == DRY) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          aborted_reg <= 1'b1;
        end else begin
          state_reg <= SPIN;
          cnt_reg   <= CW'(SPIN_T);
          drain_reg <= 1'b1;
        end
      end else if (lid_cl) begin
        if (presc_reg != PRESC_MAX) begin
          presc_reg <= presc_reg + 1'b1;
        end else begin
          presc_reg <= '0;
          if (cnt_reg != CW'(1)) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            case (state_reg)
              SOAK: begin
                state_reg <= WASH;
                cnt_reg   <= CW'(WASH_T);
              end
              WASH: begin
                state_reg <= RINSE;
                cnt_reg   <= CW'(RINSE_T);
              end
              RINSE: begin
                if (rinse_num_reg < n_extra_reg) begin
                  rinse_num_reg <= rinse_num_reg + 1'b1;
                  cnt_reg       <= CW'(RINSE_T);
                end else begin
                  state_reg     <= SPIN;
                  cnt_reg       <= CW'(SPIN_T);
                  rinse_num_reg <= '0;
                end
              end
              SPIN: begin
                if (drain_reg) begin
                  state_reg   <= IDLE;
                  cnt_reg     <= '0;
                  aborted_reg <= 1'b1;
                  drain_reg   <= 1'b0;
                end else begin
                  state_reg <= DRY;
                  cnt_reg   <= CW'(DRY_T);
                end
              end
              DRY: begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                done_reg  <= 1'b1;
              end
              default: begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
      end
    end
  end

  assign soak_signal  = (state_reg == SOAK)  & lid_cl;
  assign wash_signal  = (state_reg == WASH)  & lid_cl;
  assign rinse_signal = (state_reg == RINSE) & lid_cl;
  assign spin_signal  = (state_reg == SPIN)  & lid_cl;
  assign dry_signal   = (state_reg == DRY)   & lid_cl;
  assign paused       = (state_reg != IDLE)  & ~lid_cl;
  assign completed    = (state_reg == IDLE);
  assign done         = done_reg;
  assign aborted      = aborted_reg;
  assign rinse_num    = rinse_num_reg;
  assign remaining    = cnt_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed scenarios plus random traffic, checked each
// cycle against a queue-of-phases model counting lid-closed cycles per phase.
module tb_wash_sequencer;
  localparam int TD = 4, ST = 2, WT = 3, RT = 2, PT = 2, DT = 1, MX = 2, CW = 16, EW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0, coin = 1'b0, lid_cl = 1'b1, abort = 1'b0;
  logic [EW-1:0] extra_rinse = '0;
  logic soak_signal, wash_signal, rinse_signal, spin_signal, dry_signal;
  logic paused, completed, done, aborted;
  logic [EW-1:0] rinse_num;
  logic [CW-1:0] remaining;

  wash_sequencer #(.TICK_DIV(TD), .SOAK_T(ST), .WASH_T(WT), .RINSE_T(RT), .SPIN_T(PT),
                   .DRY_T(DT), .MAX_EXTRA(MX), .CW(CW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .coin(coin), .extra_rinse(extra_rinse), .lid_cl(lid_cl),
    .abort(abort), .soak_signal(soak_signal), .wash_signal(wash_signal),
    .rinse_signal(rinse_signal), .spin_signal(spin_signal), .dry_signal(dry_signal),
    .paused(paused), .completed(completed), .done(done), .aborted(aborted),
    .rinse_num(rinse_num), .remaining(remaining));

  always #5 clk = ~clk;

  // Reference model: the rest of the run as a list of phases, each holding the
  // number of lid-closed cycles it still needs.
  typedef enum int {K_NONE, K_SOAK, K_WASH, K_RINSE, K_SPIN, K_DRY} kind_t;
  typedef struct { kind_t kind; int idx; int left; } ph_t;
  ph_t q[$];
  bit  drain_m, done_m, aborted_m;
  int  n_cmp = 0, n_err = 0, cyc = 0;

  task automatic model_edge();
    ph_t p;
    int  n;
    if (!rst) begin
      q.delete(); drain_m = 0; done_m = 0; aborted_m = 0;
    end else if (q.size() == 0) begin
      done_m = 0;
      if (coin) begin
        n = (int'(extra_rinse) > MX) ? MX : int'(extra_rinse);
        p = '{K_SOAK, 0, ST * TD}; q.push_back(p);
        p = '{K_WASH, 0, WT * TD}; q.push_back(p);
        for (int i = 0; i <= n; i++) begin p = '{K_RINSE, i, RT * TD}; q.push_back(p); end
        p = '{K_SPIN, 0, PT * TD}; q.push_back(p);
        p = '{K_DRY, 0, DT * TD};  q.push_back(p);
        aborted_m = 0; drain_m = 0;
      end
    end else begin
      done_m = 0;
      if (abort && q[0].kind inside {K_SOAK, K_WASH, K_RINSE}) begin
        q.delete();
        p = '{K_SPIN, 0, PT * TD}; q.push_back(p);
        drain_m = 1;
      end else if (abort && q[0].kind == K_DRY) begin
        q.delete(); aborted_m = 1;
      end else if (lid_cl) begin
        q[0].left = q[0].left - 1;
        if (q[0].left == 0) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            if (drain_m) aborted_m = 1; else done_m = 1;
            drain_m = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    kind_t k;
    int    ri, left;
    #1;
    k    = (q.size() == 0) ? K_NONE : q[0].kind;
    ri   = (k == K_RINSE) ? q[0].idx : 0;
    left = (k == K_NONE) ? 0 : q[0].left;
    check("soak",      32'(soak_signal),  32'((k == K_SOAK)  && lid_cl));
    check("wash",      32'(wash_signal),  32'((k == K_WASH)  && lid_cl));
    check("rinse",     32'(rinse_signal), 32'((k == K_RINSE) && lid_cl));
    check("spin",      32'(spin_signal),  32'((k == K_SPIN)  && lid_cl));
    check("dry",       32'(dry_signal),   32'((k == K_DRY)   && lid_cl));
    check("paused",    32'(paused),       32'((k != K_NONE)  && !lid_cl));
    check("completed", 32'(completed),    32'(k == K_NONE));
    check("done",      32'(done),         32'(done_m));
    check("aborted",   32'(aborted),      32'(aborted_m));
    check("rinse_num", 32'(rinse_num),    32'(ri));
    check("remaining", 32'(remaining),    32'((left + TD - 1) / TD));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  // One run started by a coin in cycle 0; reports the first IDLE cycle, the done
  // cycle (-1 if none) and aborted as seen in cycle 1.
  task automatic run_scn(input int ex, input int abort_c, input int rst_c, input int coin2_c,
                         input int lid_lo, input int lid_hi,
                         output int idle_c, output int done_c, output int ab1);
    cyc = 0; extra_rinse = EW'(ex); coin = 1; abort = 0; lid_cl = 1; rst = 1;
    check_all();
    idle_c = -1; done_c = -1; ab1 = -1;
    for (int k = 0; k < 200 && idle_c < 0; k++) begin
      tick();
      coin = (cyc == coin2_c);
      abort = (cyc == abort_c);
      rst = !(cyc == rst_c);
      lid_cl = !(cyc >= lid_lo && cyc <= lid_hi);
      extra_rinse = EW'($urandom);
      check_all();
      if (cyc == 1) ab1 = int'(aborted);
      if (done === 1'b1) done_c = cyc;
      if (completed === 1'b1) idle_c = cyc;
    end
    coin = 0; abort = 0; rst = 1; lid_cl = 1;
    tick(); check_all();
  endtask

  int idle_c, done_c, ab1;

  initial begin
    tick(); tick(); check_all();
    check("rst_completed", 32'(completed), 32'd1);
    check("rst_remaining", 32'(remaining), 32'd0);
    rst = 1;
    tick(); check_all();

    run_scn(0, -1, -1, -1, -1, -2, idle_c, done_c, ab1);
    check("s1_idle_cyc", idle_c, 41);
    check("s1_done_cyc", done_c, 41);

    run_scn(3, -1, -1, -1, -1, -2, idle_c, done_c, ab1);
    check("s2_done_cyc", done_c, 57);

    run_scn(0, -1, -1, -1, 12, 16, idle_c, done_c, ab1);
    check("s3_done_cyc", done_c, 46);

    run_scn(0, 10, -1, -1, -1, -2, idle_c, done_c, ab1);
    check("s4_idle_cyc", idle_c, 19);
    check("s4_done_cyc", done_c, -1);
    check("s4_aborted", 32'(aborted), 32'd1);

    run_scn(1, -1, 25, 5, -1, -2, idle_c, done_c, ab1);
    check("s5_clear_aborted", ab1, 0);
    check("s5_idle_cyc", idle_c, 26);
    check("s5_done_cyc", done_c, -1);

    run_scn(0, 38, -1, -1, -1, -2, idle_c, done_c, ab1);
    check("s6_idle_cyc", idle_c, 39);
    check("s6_done_cyc", done_c, -1);
    check("s6_aborted", 32'(aborted), 32'd1);

    // Random traffic: lid flicker, aborts in every phase, mid-run coins and resets.
    for (int k = 0; k < 4000; k++) begin
      tick();
      rst = ($urandom_range(0, 299) != 0);
      coin = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      lid_cl = ($urandom_range(0, 9) != 0);
      extra_rinse = EW'($urandom);
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised wash-cycle sequencer. It is the next generation of the single-program washing-machine controller. Phase durations and the time base are set by parameters, and the block adds:
- a runtime-selectable number of extra rinses,
- lid-open pause with frozen timers,
- an abort-with-drain path,
- remaining-time, rinse-index, done and aborted status.

It sits between the coin/panel inputs and the motor/valve drivers.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clk cycles per time tick (≥1).
- SOAK_T, 60: soak duration in ticks (≥1).
- WASH_T, 60: wash duration in ticks (≥1).
- RINSE_T, 60: duration of each rinse in ticks (≥1).
- SPIN_T, 60: spin/drain duration in ticks (≥1).
- DRY_T, 60: dry duration in ticks (≥1).
- MAX_EXTRA, 3: maximum extra rinses accepted.
- CW, 16: phase-counter width; every *_T must be < 2^CW.
- EW, 2: width of extra_rinse; 2^EW-1 ≥ MAX_EXTRA.

Ports (clock and reset first):
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
- coin  in  1  start request; level-sampled.
- extra_rinse  in  EW  extra rinses requested; latched when the start is accepted.
- lid_cl  in  1  1 = lid closed.
- abort  in  1  abort request; level-sampled.
- soak_signal, wash_signal, rinse_signal, spin_signal, dry_signal  out  1 each  phase drives; at most one high.
- paused  out  1  run in progress with lid open.
- completed  out  1  high in IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  last run ended via abort.
- rinse_num  out  EW  current rinse index, 0-based; 0 outside RINSE.
- remaining  out  CW  ticks left in the current phase; 0 in IDLE.

## Operation
- States: IDLE, SOAK, WASH, RINSE, SPIN, DRY.
- Reset values: state=IDLE, prescaler=0, phase counter=0, rinse_num=0, aborted=0, done=0, completed=1, all phase drives=0, paused=0.

Start:
- In IDLE, coin=1 moves the block to SOAK and loads the counter with SOAK_T.
- The same edge clears the prescaler, clears aborted and latches n_extra = min(extra_rinse, MAX_EXTRA).
- coin is ignored outside IDLE.

Running (any non-IDLE state) with lid_cl=1:
- The prescaler counts 0..TICK_DIV-1 and wraps.
- A tick occurs on the cycle the prescaler equals TICK_DIV-1.
- On a tick the phase counter decrements.
- A tick with counter==1 ends the phase instead: the next phase's duration is loaded and the prescaler is already 0.

Phase sequence:
- SOAK → WASH → RINSE.
- RINSE: if rinse_num < n_extra, increment rinse_num and reload RINSE_T. Otherwise go to SPIN and clear rinse_num.
- SPIN → DRY.
- DRY → IDLE. done=1 for exactly the first IDLE cycle.

Lid open (lid_cl=0) while running:
- Prescaler, counter, state and rinse_num are frozen.
- All phase drives are 0 and paused=1.
- On lid close, counting resumes from the frozen values with no lost or extra cycles.

Abort (abort=1 while running, checked before tick logic):
- From SOAK, WASH or RINSE: go to SPIN, load SPIN_T, clear prescaler, set the abort-in-progress flag.
- Abort in SPIN: ignored.
- Abort in DRY: go to IDLE immediately.
- Any run that set abort-in-progress or left DRY by abort ends with aborted=1 and done=0.
- After an abort-drain, SPIN exits to IDLE, not DRY.
- Abort is honoured even with the lid open. The drain then proceeds when the lid closes.

Outputs:
- Phase drive = (state==phase) & lid_cl, combinational from registered state.
- completed = (state==IDLE).
- remaining = the phase counter.
- Reset (rst=0) mid-run overrides everything and returns to IDLE on the next edge.

## Timing
- Start latency: coin sampled high at edge E0 gives soak_signal high in the cycle after E0.
- Each phase lasts exactly *_T × TICK_DIV lid-closed cycles.
- A normal run lasts (SOAK_T+WASH_T+(1+n_extra)·RINSE_T+SPIN_T+DRY_T)·TICK_DIV cycles, plus lid-open cycles.
- done is asserted in the cycle after the last DRY cycle.
- Abort takes effect at the next edge. SPIN drains for the full SPIN_T×TICK_DIV cycles.
- coin and abort high in the same IDLE cycle: start is accepted and abort is ignored.
- coin held high through completion restarts the block one cycle after done.
- TICK_DIV=1: a tick occurs every running cycle.

## Test plan
Common configuration: TICK_DIV=4, SOAK_T=2, WASH_T=3, RINSE_T=2, SPIN_T=2, DRY_T=1, MAX_EXTRA=2.

1. Normal run, extra_rinse=0, coin pulsed at cycle 0 → soak cycles 1–8, wash 9–20, rinse 21–28, spin 29–36, dry 37–40; done=1 only at cycle 41; completed=1 from 41.
2. extra_rinse=3 (saturates to 2) → rinse cycles 21–44 with rinse_num 0,1,2 in successive 8-cycle blocks; done at cycle 57.
3. lid_cl=0 for cycles 12–16 in WASH → drives 0, paused=1, remaining frozen; done at cycle 46.
4. abort=1 at cycle 10 (WASH) → spin cycles 11–18, no dry; IDLE at 19 with aborted=1, done=0. The next coin clears aborted.
5. rst=0 at cycle 25 (RINSE) → cycle 26: IDLE, all outputs at reset values. A coin during a run (cycle 5) does not change state or timing.
6. Abort at cycle 38 (DRY) → IDLE at cycle 39, aborted=1, done=0.
